// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
// Purpose: bundles the issue handshake, the writeback report, the flush and
//          the status outputs of the register scoreboard.
// Signals:
//   issue_valid/issue_ready   decode -> scoreboard handshake (ready is comb.)
//   issue_rs/_used, issue_rt/_used  source operands and their use flags
//   issue_rd/issue_wr         destination register and its write flag
//   wb_valid/wb_rd            writeback completion reported this cycle
//   flush                     discard every pending write
//   busy_mask                 registered per-register busy flags
//   wb_err                    sticky writeback-without-pending-write flag
//   stall_cnt                 saturating stalled-issue cycle count
// Modports: master = decode/writeback side, slave = scoreboard.
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int STALL_W = 16
);
  logic               issue_valid;
  logic               issue_ready;
  logic [AW-1:0]      issue_rs;
  logic               issue_rs_used;
  logic [AW-1:0]      issue_rt;
  logic               issue_rt_used;
  logic [AW-1:0]      issue_rd;
  logic               issue_wr;
  logic               wb_valid;
  logic [AW-1:0]      wb_rd;
  logic               flush;
  logic [NREG-1:0]    busy_mask;
  logic               wb_err;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
           issue_rd, issue_wr, wb_valid, wb_rd, flush,
    input  issue_ready, busy_mask, wb_err, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
           issue_rd, issue_wr, wb_valid, wb_rd, flush,
    output issue_ready, busy_mask, wb_err, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Purpose: tracks architectural registers with outstanding writebacks and
//          holds instruction issue until source operands are readable and
//          the destination's pending-write counter has room.
// Ports:
//   clk   clock, all state updates on posedge
//   rst   asynchronous active-low reset
//   sb    reg_scoreboard_if.slave: issue handshake, writeback report,
//         flush, busy_mask, wb_err, stall_cnt
// Register 0 is hardwired zero: never busy, never counted, writebacks to it
// are ignored.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  logic [CNT_W-1:0]   cnt_q [NREG];
  logic [CNT_W-1:0]   cnt_d [NREG];
  logic               wb_err_q, wb_err_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [NREG-1:0] eb;
  logic            raw, full, ready, accept;

  // Effective busy: a register whose last pending write completes this
  // cycle is already readable, because the register file writes in the
  // first half-cycle and reads in the second.
  always_comb begin
    eb = '0;
    for (int i = 1; i < NREG; i++) begin
      eb[i] = (cnt_q[i] != '0) &&
              !(sb.wb_valid && (sb.wb_rd == AW'(i)) && (cnt_q[i] == CNT_ONE));
    end
  end

  always_comb begin
    raw = (sb.issue_rs_used && eb[sb.issue_rs]) ||
          (sb.issue_rt_used && eb[sb.issue_rt]);
    // A writeback to rd in the same cycle frees a slot, so a saturated
    // counter still accepts one more write.
    full = sb.issue_wr && (sb.issue_rd != '0) &&
           (cnt_q[sb.issue_rd] == CNT_MAX) &&
           !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    ready  = !sb.flush && !raw && !full;
    accept = sb.issue_valid && ready;
  end

  // Next-state: per-register counters, sticky error, saturating stall count.
  always_comb begin
    logic inc, dec;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = '0;
    end
    for (int i = 1; i < NREG; i++) begin
      inc = accept && sb.issue_wr && (sb.issue_rd == AW'(i));
      dec = sb.wb_valid && (sb.wb_rd == AW'(i)) && (cnt_q[i] != '0);
      // inc never overflows: a full counter only accepts with a same-cycle
      // decrement on the same register.
      cnt_d[i] = sb.flush ? '0
                          : cnt_q[i] + CNT_W'(inc) - CNT_W'(dec);
    end

    wb_err_d = wb_err_q ||
               (sb.wb_valid && (sb.wb_rd != '0) &&
                (cnt_q[sb.wb_rd] == '0) && !sb.flush);

    stall_d = stall_q;
    if (sb.issue_valid && !ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      wb_err_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wb_err_q <= wb_err_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb.busy_mask[i] = (cnt_q[i] != '0);
    end
  end

  assign sb.issue_ready = ready;
  assign sb.wb_err      = wb_err_q;
  assign sb.stall_cnt   = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
// Purpose: self-checking bench for reg_scoreboard. Table vectors carry the
// inputs for one cycle, the expected combinational issue_ready and the
// expected busy_mask / wb_err after the clock edge. Expected post-edge
// state is queued when a vector is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 16;

  logic clk;
  logic rst;

  reg_scoreboard_if #(.NREG(NREG), .AW(AW), .STALL_W(STALL_W)) sbif ();

  reg_scoreboard #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs;
    logic          rsu;
    logic [AW-1:0] rt;
    logic          rtu;
    logic [AW-1:0] rd;
    logic          wr;
    logic          wbv;
    logic [AW-1:0] wbr;
    logic          fl;
    logic          rdy;
    logic [31:0]   busy;
    logic          err;
  } vec_t;

  typedef struct {
    logic [31:0]        busy;
    logic               err;
    logic [STALL_W-1:0] stall;
    int                 idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  logic [STALL_W-1:0] exp_stall = '0;

  function automatic vec_t mk(logic v, int rs, logic rsu, int rt, logic rtu,
                              int rd, logic wr, logic wbv, int wbr, logic fl,
                              logic rdy, logic [31:0] busy, logic err);
    vec_t t;
    t.v = v;   t.rs = AW'(rs); t.rsu = rsu; t.rt = AW'(rt); t.rtu = rtu;
    t.rd = AW'(rd); t.wr = wr; t.wbv = wbv; t.wbr = AW'(wbr); t.fl = fl;
    t.rdy = rdy; t.busy = busy; t.err = err;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    sbif.issue_valid = 0; sbif.issue_rs = '0; sbif.issue_rs_used = 0;
    sbif.issue_rt = '0; sbif.issue_rt_used = 0; sbif.issue_rd = '0;
    sbif.issue_wr = 0; sbif.wb_valid = 0; sbif.wb_rd = '0; sbif.flush = 0;
  endtask

  task automatic step(int idx);
    vec_t t;
    exp_t e;
    t = tbl[idx];
    @(negedge clk);
    sbif.issue_valid = t.v; sbif.issue_rs = t.rs; sbif.issue_rs_used = t.rsu;
    sbif.issue_rt = t.rt; sbif.issue_rt_used = t.rtu; sbif.issue_rd = t.rd;
    sbif.issue_wr = t.wr; sbif.wb_valid = t.wbv; sbif.wb_rd = t.wbr;
    sbif.flush = t.fl;
    #1;
    chk($sformatf("v%0d ready", idx), 32'(sbif.issue_ready), 32'(t.rdy));
    if (t.v && !t.rdy && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    e.busy = t.busy; e.err = t.err; e.stall = exp_stall; e.idx = idx;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk($sformatf("v%0d busy_mask", e.idx), sbif.busy_mask, e.busy);
    chk($sformatf("v%0d wb_err", e.idx), 32'(sbif.wb_err), 32'(e.err));
    chk($sformatf("v%0d stall_cnt", e.idx), 32'(sbif.stall_cnt), 32'(e.stall));
  endtask

  initial begin
    //        v rs u rt u rd wr wbv wbr fl rdy busy       err
    // Build up cnt[5]=2 and one stall, then reset mid-run.
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0, 0, 0, 1, 32'h20,   0));
    tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0, 0, 0, 1, 32'h20,   0));
    tbl.push_back(mk(1, 5,1, 0,0, 0,0, 0, 0, 0, 0, 32'h20,   0));
    // After reset rs=5 is readable.
    tbl.push_back(mk(1, 5,1, 0,0, 0,0, 0, 0, 0, 1, 32'h0,    0));
    // RAW on rs with same-cycle bypass, then RAW on rt.
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 0, 0, 1, 32'h80,   0));
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0, 0, 0, 0, 32'h80,   0));
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 1, 7, 0, 1, 32'h0,    0));
    tbl.push_back(mk(1, 0,0, 0,0, 8,1, 0, 0, 0, 1, 32'h100,  0));
    tbl.push_back(mk(1, 0,0, 8,1, 0,0, 0, 0, 0, 0, 32'h100,  0));
    tbl.push_back(mk(1, 0,0, 8,0, 0,0, 0, 0, 0, 1, 32'h100,  0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1, 8, 0, 1, 32'h0,    0));
    // Counter full on rd=3; fourth write accepted only with same-cycle wb.
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0, 0, 0, 1, 32'h8,    0));
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0, 0, 0, 1, 32'h8,    0));
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0, 0, 0, 1, 32'h8,    0));
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0, 0, 0, 0, 32'h8,    0));
    tbl.push_back(mk(1, 0,0, 0,0, 3,1, 1, 3, 0, 1, 32'h8,    0));
    // Drain: bypass applies only to the last pending write (cnt==1).
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1, 3, 0, 1, 32'h8,    0));
    tbl.push_back(mk(1, 3,1, 0,0, 0,0, 1, 3, 0, 0, 32'h8,    0));
    tbl.push_back(mk(1, 3,1, 0,0, 0,0, 1, 3, 0, 1, 32'h0,    0));
    // Register 0: writes not counted, reads never busy, wb ignored.
    tbl.push_back(mk(1, 0,0, 0,0, 0,1, 0, 0, 0, 1, 32'h0,    0));
    tbl.push_back(mk(1, 0,1, 0,1, 0,0, 0, 0, 0, 1, 32'h0,    0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0, 0, 1, 32'h0,    0));
    // Flush discards pending writes, wb and accept in the same cycle.
    tbl.push_back(mk(1, 0,0, 0,0, 4,1, 0, 0, 0, 1, 32'h10,   0));
    tbl.push_back(mk(1, 0,0, 0,0, 9,1, 0, 0, 0, 1, 32'h210,  0));
    tbl.push_back(mk(1, 0,0, 0,0, 9,1, 0, 0, 0, 1, 32'h210,  0));
    tbl.push_back(mk(1, 0,0, 0,0, 4,1, 1, 4, 1, 0, 32'h0,    0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,12, 1, 0, 32'h0,    0));
    // Writeback error is sticky; a wr with wb on an empty counter still counts.
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,12, 0, 1, 32'h0,    1));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0, 1, 32'h0,    1));
    tbl.push_back(mk(1, 0,0, 0,0,12,1, 1,12, 0, 1, 32'h1000, 1));

    drive_idle();
    rst = 1'b0;
    #1;
    chk("reset busy_mask", sbif.busy_mask, 32'h0);
    chk("reset wb_err", 32'(sbif.wb_err), 32'h0);
    chk("reset stall_cnt", 32'(sbif.stall_cnt), 32'h0);
    chk("reset ready", 32'(sbif.issue_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) step(i);

    // Asynchronous reset mid-run: state clears without a clock edge.
    @(negedge clk);
    drive_idle();
    #2;
    rst = 1'b0;
    #1;
    exp_stall = '0;
    chk("midreset busy_mask", sbif.busy_mask, 32'h0);
    chk("midreset wb_err", 32'(sbif.wb_err), 32'h0);
    chk("midreset stall_cnt", 32'(sbif.stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 3; i < tbl.size(); i++) step(i);

    // Stall saturation: cnt[12]=1 holds a RAW hazard on rs=12.
    @(negedge clk);
    drive_idle();
    sbif.issue_valid = 1; sbif.issue_rs = AW'(12); sbif.issue_rs_used = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat ready", 32'(sbif.issue_ready), 32'h0);
    chk("sat stall_cnt", 32'(sbif.stall_cnt), 32'hFFFF);
    chk("sat wb_err", 32'(sbif.wb_err), 32'h1);
    chk("sat busy_mask", sbif.busy_mask, 32'h1000);

    // Flush does not clear stall_cnt.
    @(negedge clk);
    drive_idle();
    sbif.flush = 1;
    @(posedge clk);
    #1;
    chk("flush keeps stall_cnt", 32'(sbif.stall_cnt), 32'hFFFF);
    chk("flush clears busy", sbif.busy_mask, 32'h0);
    @(negedge clk);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
